// File: rtl/block_fetch_2x2.sv
// block_fetch_2x2: walks a source frame in 2x2 tiles, reading four pixels
// per tile from a 1-cycle-latency memory and presenting them on a valid/ready port.
module block_fetch_2x2 #(
  parameter int IMG_WIDTH_IN  = 160,
  parameter int IMG_HEIGHT_IN = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  p0,
  output logic [7:0]  p1,
  output logic [7:0]  p2,
  output logic [7:0]  p3,
  output logic [12:0] blk_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RD2,
    RD3,
    WAIT,
    OUT,
    FIN
  } state_t;

  localparam logic [15:0] W16      = 16'(IMG_WIDTH_IN);
  localparam logic [15:0] ROW_STEP = 16'(2 * IMG_WIDTH_IN);
  localparam logic [15:0] BX_LAST  = 16'(IMG_WIDTH_IN / 2 - 1);
  localparam logic [15:0] BY_LAST  = 16'(IMG_HEIGHT_IN / 2 - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] bx;
  logic [15:0] by;
  logic [15:0] row_base;
  logic [15:0] base;
  logic [15:0] addr_q;
  logic        xfer;
  logic        last_col;
  logic        last_row;

  assign xfer     = (state == OUT) && out_ready;
  assign last_col = (bx == BX_LAST);
  assign last_row = (by == BY_LAST);
  assign base     = row_base + bx + bx;

  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RD0;
      RD0:  state_nxt = RD1;
      RD1:  state_nxt = RD2;
      RD2:  state_nxt = RD3;
      RD3:  state_nxt = WAIT;
      WAIT: state_nxt = OUT;
      OUT: begin
        if (xfer) begin
          state_nxt = (last_col && last_row) ? FIN : RD0;
        end
      end
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address is driven only in read states; elsewhere it holds the last one.
  always_comb begin
    mem_addr = addr_q;
    unique case (state)
      RD0: mem_addr = base;
      RD1: mem_addr = base + 16'd1;
      RD2: mem_addr = base + W16;
      RD3: mem_addr = base + W16 + 16'd1;
      default: mem_addr = addr_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= mem_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bx       <= '0;
      by       <= '0;
      row_base <= '0;
      blk_idx  <= '0;
    end else if (state == IDLE && start) begin
      bx       <= '0;
      by       <= '0;
      row_base <= '0;
      blk_idx  <= '0;
    end else if (xfer) begin
      blk_idx <= blk_idx + 13'd1;
      if (!last_col) begin
        bx <= bx + 16'd1;
      end else if (!last_row) begin
        bx       <= '0;
        by       <= by + 16'd1;
        row_base <= row_base + ROW_STEP;
      end
    end
  end

  // Read data trails its address by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0 <= '0;
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
    end else begin
      unique case (state)
        RD1:  p0 <= mem_rdata;
        RD2:  p1 <= mem_rdata;
        RD3:  p2 <= mem_rdata;
        WAIT: p3 <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_fetch_2x2.sv
// tb_block_fetch_2x2: scoreboard bench for the 2x2 block fetcher
// against a memory model returning mem[a] = a[7:0].
module tb_block_fetch_2x2;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int NB = (W / 2) * (H / 2);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [7:0]  p0, p1, p2, p3;
  logic [12:0] blk_idx;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  typedef struct {
    logic [7:0]  p0;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic [7:0]  p3;
    logic [12:0] idx;
  } blk_t;

  blk_t sb[$];
  int   passed = 0;
  int   total  = 0;

  block_fetch_2x2 #(
    .IMG_WIDTH_IN (W),
    .IMG_HEIGHT_IN(H)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .p0       (p0),
    .p1       (p1),
    .p2       (p2),
    .p3       (p3),
    .blk_idx  (blk_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem_addr[7:0];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string pre);
    chk({pre, "_out_valid"}, out_valid, 0);
    chk({pre, "_busy"}, busy, 0);
    chk({pre, "_done"}, done, 0);
    chk({pre, "_mem_addr"}, mem_addr, 0);
    chk({pre, "_p0"}, p0, 0);
    chk({pre, "_p1"}, p1, 0);
    chk({pre, "_p2"}, p2, 0);
    chk({pre, "_p3"}, p3, 0);
    chk({pre, "_blk_idx"}, blk_idx, 0);
  endtask

  task automatic push_frame();
    blk_t b;
    int   base;
    for (int y = 0; y < H / 2; y++) begin
      for (int x = 0; x < W / 2; x++) begin
        base  = y * 2 * W + 2 * x;
        b.p0  = 8'(base);
        b.p1  = 8'(base + 1);
        b.p2  = 8'(base + W);
        b.p3  = 8'(base + W + 1);
        b.idx = 13'(y * (W / 2) + x);
        sb.push_back(b);
      end
    end
  endtask

  task automatic cmp_block();
    blk_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("blk_idx", blk_idx, e.idx);
      chk("p0", p0, e.p0);
      chk("p1", p1, e.p1);
      chk("p2", p2, e.p2);
      chk("p3", p3, e.p3);
    end
  endtask

  task automatic run_frame(input bit bp_en, input bit inj_en);
    int          lat;
    int          xfers;
    int          dones;
    int          bp;
    int          last_x;
    bit          post_bp;
    blk_t        snap;
    logic [15:0] snap_a;
    push_frame();
    out_ready = 1'b1;
    start     = 1'b1;
    cyc();
    start = 1'b0;
    lat   = 1;
    while (!out_valid && lat < 20) begin
      cyc();
      lat++;
    end
    chk("first_valid_latency", lat, 6);
    xfers   = 0;
    dones   = 0;
    bp      = 0;
    last_x  = -10;
    post_bp = 1'b0;
    snap_a  = '0;
    snap    = '{default: '0};
    for (int it = 0; it < 40000; it++) begin
      out_ready = 1'b1;
      start     = 1'b0;
      if (inj_en && xfers < NB && (it % 997 == 500 || it == 2)) start = 1'b1;
      if (post_bp) begin
        chk("bp_released", out_valid, 0);
        post_bp = 1'b0;
      end
      if (bp_en && out_valid && xfers == 3 && bp <= 10) begin
        if (bp == 0) begin
          snap.p0 = p0; snap.p1 = p1; snap.p2 = p2; snap.p3 = p3;
          snap.idx = blk_idx;
          snap_a = mem_addr;
        end else begin
          chk("bp_valid", out_valid, 1);
          chk("bp_p0", p0, snap.p0);
          chk("bp_p1", p1, snap.p1);
          chk("bp_p2", p2, snap.p2);
          chk("bp_p3", p3, snap.p3);
          chk("bp_idx", blk_idx, snap.idx);
          chk("bp_addr", mem_addr, snap_a);
        end
        if (bp < 10) out_ready = 1'b0;
        else post_bp = 1'b1;
        bp++;
      end
      if (done) begin
        dones++;
        chk("done_after_last", (last_x == it - 1 && xfers == NB), 1);
      end
      if (out_valid && out_ready) begin
        cmp_block();
        xfers++;
        last_x = it;
      end
      if (dones > 0 && it - last_x > 10) break;
      cyc();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("xfer_count", xfers, NB);
    chk("done_count", dones, 1);
    chk("sb_empty", sb.size(), 0);
    chk("idle_after_frame", busy, 0);
  endtask

  task automatic reset_mid_frame();
    int xfers;
    bit any;
    blk_t e;
    push_frame();
    out_ready = 1'b1;
    start     = 1'b1;
    cyc();
    start = 1'b0;
    xfers = 0;
    for (int it = 0; it < 1000 && xfers < 37; it++) begin
      if (out_valid) begin
        e = sb.pop_front();
        chk("pre_rst_idx", blk_idx, e.idx);
        xfers++;
      end
      cyc();
    end
    chk("pre_rst_count", xfers, 37);
    cyc();
    cyc();
    chk("rd2_addr", mem_addr, 74 + W);
    chk("rd2_p0", p0, 74);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    sb.delete();
    cyc();
    cyc();
    rst_n = 1'b1;
    any   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (done || busy) any = 1'b1;
    end
    chk("no_done_after_rst", any, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    cyc();
    cyc();
    chk_zero("reset");
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("idle_no_start", busy, 0);
    run_frame(1'b1, 1'b1);
    reset_mid_frame();
    run_frame(1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/block_fetch_2x2.md
BLOCK_FETCH_2X2 -- requirements
Module: block_fetch_2x2

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH_IN, default 160, meaning the source image width in pixels (even).
REQ-002 The block SHALL have parameter IMG_HEIGHT_IN, default 120, meaning the source image height in pixels (even).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, request to fetch one full frame; sampled only in IDLE.
REQ-006 The block SHALL have port mem_addr, output, 16, source-frame read address (row-major, y*IMG_WIDTH_IN+x).
REQ-007 The block SHALL have port mem_rdata, input, 8, read data; valid exactly one cycle after its mem_addr.
REQ-008 The block SHALL have ports p0, p1, p2, p3, output, 8 each, the 2x2 block pixels at (x,y), (x+1,y), (x,y+1), (x+1,y+1).
REQ-009 The block SHALL have port blk_idx, output, 13, output-image index of the presented block (by*IMG_WIDTH_IN/2+bx).
REQ-010 The block SHALL have port out_valid, output, 1, p0..p3 and blk_idx are valid.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts the block; a transfer occurs when out_valid and out_ready are both 1.
REQ-012 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse after the last block transfers.

Function
REQ-014 FSM states SHALL be IDLE, RD0, RD1, RD2, RD3, WAIT, OUT, FIN.
REQ-015 IDLE: start=1 SHALL clear bx, by and row_base to 0 and move to RD0; start=0 SHALL stay in IDLE.
REQ-016 mem_addr SHALL be base in RD0, base+1 in RD1, base+IMG_WIDTH_IN in RD2, base+IMG_WIDTH_IN+1 in RD3, and hold its last value elsewhere, where base = row_base + 2*bx.
REQ-017 mem_rdata SHALL be captured into p0 in RD1, p1 in RD2, p2 in RD3, and p3 in WAIT; the sequence RD0->RD1->RD2->RD3->WAIT->OUT SHALL be unconditional.
REQ-018 OUT: out_valid SHALL be 1, and p0..p3 and blk_idx SHALL stay stable until the transfer occurs.
REQ-019 On a transfer with bx<IMG_WIDTH_IN/2-1, bx SHALL increment and the FSM SHALL move to RD0.
REQ-020 On a transfer with bx=IMG_WIDTH_IN/2-1 and by<IMG_HEIGHT_IN/2-1, bx SHALL clear to 0, by SHALL increment, row_base SHALL add 2*IMG_WIDTH_IN, and the FSM SHALL move to RD0.
REQ-021 On a transfer of the last block (bx=IMG_WIDTH_IN/2-1 and by=IMG_HEIGHT_IN/2-1), the FSM SHALL move to FIN.
REQ-022 FIN SHALL assert done for exactly one cycle and then return to IDLE.
REQ-023 start asserted outside IDLE SHALL be ignored; the FSM SHALL NOT buffer it.
REQ-024 The first out_valid SHALL occur 6 cycles after start is sampled in IDLE; with out_ready held at 1, blocks SHALL issue one per 6 cycles, 4800 per default frame.
REQ-025 The block SHALL use no multipliers; row_base and blk_idx SHALL be maintained incrementally, with blk_idx incrementing by 1 on every transfer.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, with out_valid, busy and done at 0, and mem_addr, p0..p3, blk_idx, bx, by and row_base at 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame without a done pulse; a new start is required after release.

Verification
REQ-028 Memory mem[a]=a[7:0], out_ready=1, start pulsed: first block p0=0, p1=1, p2=160, p3=161, blk_idx=0, with out_valid 6 cycles after start.
REQ-029 Same setup: block blk_idx=80 has base 320, so p0=64, p1=65, p2=224, p3=225; the last block (blk_idx=4799) has base 19038, and done pulses once after its transfer.
REQ-030 Backpressure: out_ready=0 for 10 cycles in OUT -> out_valid, p0..p3 and blk_idx held constant and mem_addr unchanged; the transfer completes on the first out_ready=1.
REQ-031 start pulsed while busy -> no effect on bx, by or the frame sequence; exactly 4800 transfers occur and done pulses once.
REQ-032 rst_n pulsed low during RD2 of block 37 -> all outputs 0 at once, no done pulse; a new start restarts at blk_idx=0.
